// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the MIPS IF stage: bubble encoding, default reset
// PC, fetch FSM state encoding and small PC arithmetic helpers.
package instruction_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  // sll $0,$0,0 -- architecturally a no-op, used for pipeline bubbles
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES       = 32'h0000_0004;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_REQ      = 2'd1,
    FETCH_BUF_FULL = 2'd2
  } fetch_state_e;

  // One fetched word together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  // Sequential successor; wraps silently past 32'hFFFF_FFFC
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

  // Branch displacement: sign-extended word offset converted to bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_target_gen.sv
// Redirect target calculation for the instruction currently in ID.
// Purely combinational; priority is register jump, then J/JAL, then branch.
module pc_target_gen
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc_id,
  // Low 26 bits of instr_id: J index field, whose low half is the branch immediate
  input  logic [25:0] instr_field,
  input  logic [31:0] jr_pc,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  output logic [31:0] redirect_target,
  output logic        redirect_any
);

  logic [31:0] seq_pc;

  // Select the redirect target by jump-kind priority
  always_comb begin
    seq_pc       = next_seq_pc(pc_id);
    redirect_any = jump_branch | jump_target | jump_reg;
    if (jump_reg) begin
      redirect_target = jr_pc;
    end else if (jump_target) begin
      // J/JAL keep the region bits of the delay-slot address
      redirect_target = {seq_pc[31:28], instr_field, 2'b00};
    end else if (jump_branch) begin
      redirect_target = seq_pc + branch_offset(instr_field[15:0]);
    end else begin
      redirect_target = seq_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: issues fetch requests with a req/ready handshake, feeds the
// IF/ID register, absorbs a decode stall with a one-entry skid buffer and
// applies jump/branch redirects after the one-instruction delay slot.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        instr_valid_id
);

  fetch_state_e state_q, state_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  fetch_word_t  skid_q, skid_d;
  logic [31:0]  pc_id_q, pc_id_d;
  logic [31:0]  instr_id_q, instr_id_d;
  logic         valid_id_q, valid_id_d;
  logic         redir_pending_q, redir_pending_d;
  logic [31:0]  redir_pc_q, redir_pc_d;

  logic [31:0]  redirect_target;
  logic         redirect_any;
  logic         redirect_fire;
  logic         id_can_load;
  logic [31:0]  after_word_pc;

  pc_target_gen u_pc_target_gen (
    .pc_id           (pc_id_q),
    .instr_field     (instr_id_q[25:0]),
    .jr_pc           (jr_pc),
    .jump_branch     (jump_branch),
    .jump_target     (jump_target),
    .jump_reg        (jump_reg),
    .redirect_target (redirect_target),
    .redirect_any    (redirect_any)
  );

  // A redirect only counts when a real instruction leaves ID this cycle
  always_comb begin
    redirect_fire = valid_id_q & ~stall & redirect_any;
    id_can_load   = ~stall | ~valid_id_q;
  end

  // Fetch address to use once the outstanding word (the delay slot when redirecting) is accepted
  always_comb begin
    if (redirect_fire) begin
      after_word_pc = redirect_target;
    end else if (redir_pending_q) begin
      after_word_pc = redir_pc_q;
    end else begin
      after_word_pc = next_seq_pc(fetch_pc_q);
    end
  end

  // Fetch FSM next state, IF/ID register, skid buffer and deferred redirect
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    skid_d          = skid_q;
    pc_id_d         = pc_id_q;
    instr_id_d      = instr_id_q;
    valid_id_d      = valid_id_q;
    redir_pending_d = redir_pending_q;
    redir_pc_d      = redir_pc_q;

    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
        if (id_can_load) begin
          valid_id_d = 1'b0;
          instr_id_d = NOP_INSTR;
        end else begin
          valid_id_d = valid_id_q;
        end
      end

      FETCH_REQ: begin
        if (imem_ready) begin
          // Word accepted: the deferred redirect (if any) is consumed here
          fetch_pc_d      = after_word_pc;
          redir_pending_d = 1'b0;
          if (id_can_load) begin
            pc_id_d    = fetch_pc_q;
            instr_id_d = imem_rdata;
            valid_id_d = 1'b1;
          end else begin
            // ID is stalled on a real instruction: park the word
            skid_d.pc    = fetch_pc_q;
            skid_d.instr = imem_rdata;
            state_d      = FETCH_BUF_FULL;
          end
        end else begin
          if (id_can_load) begin
            valid_id_d = 1'b0;
            instr_id_d = NOP_INSTR;
          end else begin
            valid_id_d = valid_id_q;
          end
          // Delay slot still outstanding: remember where to go after it
          if (redirect_fire) begin
            redir_pending_d = 1'b1;
            redir_pc_d      = redirect_target;
          end else begin
            redir_pending_d = redir_pending_q;
          end
        end
      end

      FETCH_BUF_FULL: begin
        if (!stall) begin
          pc_id_d    = skid_q.pc;
          instr_id_d = skid_q.instr;
          valid_id_d = 1'b1;
          state_d    = FETCH_REQ;
          // The skid word is the delay slot, so the target is fetched next
          if (redirect_fire) begin
            fetch_pc_d = redirect_target;
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
        end else begin
          state_d = FETCH_BUF_FULL;
        end
      end

      default: begin
        state_d         = FETCH_IDLE;
        valid_id_d      = 1'b0;
        instr_id_d      = NOP_INSTR;
        redir_pending_d = 1'b0;
      end
    endcase

    imem_req_d = (state_d == FETCH_REQ);
  end

  // State and datapath registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FETCH_IDLE;
      imem_req_q      <= 1'b0;
      fetch_pc_q      <= RESET_PC;
      skid_q          <= {32'h0000_0000, NOP_INSTR};
      pc_id_q         <= 32'h0000_0000;
      instr_id_q      <= NOP_INSTR;
      valid_id_q      <= 1'b0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      imem_req_q      <= imem_req_d;
      fetch_pc_q      <= fetch_pc_d;
      skid_q          <= skid_d;
      pc_id_q         <= pc_id_d;
      instr_id_q      <= instr_id_d;
      valid_id_q      <= valid_id_d;
      redir_pending_q <= redir_pending_d;
      redir_pc_q      <= redir_pc_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign imem_addr      = fetch_pc_q;
  assign pc_id          = pc_id_q;
  assign instr_id       = instr_id_q;
  assign instr_valid_id = valid_id_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. The bench plays both instruction memory
// (variable latency) and decode (stall / jump flags). A program-order model
// predicts every instruction decode consumes: sequential flow, with a taken
// jump redirecting after its delay slot.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        jump_branch = 1'b0;
  logic        jump_target = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_pc = 32'h0000_0000;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        instr_valid_id;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .jump_branch(jump_branch), .jump_target(jump_target), .jump_reg(jump_reg),
    .jr_pc(jr_pc), .pc_id(pc_id), .instr_id(instr_id), .instr_valid_id(instr_valid_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // knobs
  bit          directed;
  bit          mem_ident;
  int          lat_fixed;
  int          stall_pct;
  int          jump_pct;
  int          gap_expect;
  int          gap_skip;
  logic [31:0] ovr     [logic [31:0]];
  int          lat_ovr [logic [31:0]];

  // memory responder state
  bit          prev_req;
  bit          prev_ready;
  logic [31:0] prev_addr;
  int          lat_left;

  // program-order model
  logic [31:0] exp_pc;
  bit          in_delay;
  logic [31:0] saved_target;
  int          consumed;
  longint      cyc;
  longint      last_cons;

  // hold tracking and directed scripts
  bit          hold_prev;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  bit          st_done;
  int          st_cnt;
  int          jr_st;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    if (mem_ident) return a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int pick_lat(input logic [31:0] a);
    if (lat_ovr.exists(a)) return lat_ovr[a];
    if (lat_fixed >= 0) return lat_fixed;
    return ($urandom_range(1) == 1) ? 0 : int'($urandom_range(3, 1));
  endfunction

  // Architectural redirect target, computed arithmetically from the word
  function automatic logic [31:0] model_target(input logic [31:0] p, input logic [31:0] w,
                                               input logic jr, input logic j, input logic br,
                                               input logic [31:0] rpc);
    logic [31:0] nxt;
    int          off;
    nxt = p + 32'd4;
    off = int'($signed(w[15:0]));
    if (jr) return rpc;
    if (j) return (nxt & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    return nxt + 32'(off * 4);
  endfunction

  task automatic set_phase(input int lat, input int sp, input int jp, input int gap);
    lat_fixed  = lat;
    stall_pct  = sp;
    jump_pct   = jp;
    gap_expect = gap;
    gap_skip   = 2;
  endtask

  task automatic clear_bench_state();
    prev_req   = 1'b0;
    prev_ready = 1'b0;
    prev_addr  = 32'h0;
    lat_left   = 0;
    exp_pc     = RESET_PC;
    in_delay   = 1'b0;
    hold_prev  = 1'b0;
    gap_skip   = 2;
  endtask

  // One clock of bench activity, performed at the falling edge
  task automatic tick();
    logic [2:0] m;
    @(negedge clk);
    cyc++;
    // output-level rules
    if (!instr_valid_id) check_eq("bubble_nop", instr_id, NOP);
    if (hold_prev) begin
      check_eq("hold_pc", pc_id, held_pc);
      check_eq("hold_instr", instr_id, held_instr);
      check_eq("hold_valid", 32'(instr_valid_id), 32'd1);
    end
    if (prev_req && !prev_ready && imem_req) check_eq("addr_stable", imem_addr, prev_addr);

    // instruction memory
    if (imem_req && !(prev_req && !prev_ready)) lat_left = pick_lat(imem_addr);
    if (imem_req && lat_left == 0) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom();
      if (imem_req) lat_left--;
    end

    // decode side
    stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
    if (directed) begin
      if (!st_done && imem_req && imem_ready && imem_addr == 32'h10) begin
        st_cnt  = 4;
        st_done = 1'b1;
      end
      if (st_cnt > 0) begin
        if (st_cnt < 4) check_eq("buf_full_req", 32'(imem_req), 32'd0);
        stall = 1'b1;
        st_cnt--;
      end
      if (instr_valid_id && pc_id == 32'h20) jump_branch = 1'b1;
      if (instr_valid_id && pc_id == 32'h40) jump_target = 1'b1;
      if (instr_valid_id && pc_id == 32'h408) begin
        jump_reg = 1'b1;
        jr_pc    = 32'h0000_1000;
        if (jr_st < 2) begin
          stall = 1'b1;
          jr_st++;
        end
      end
    end else begin
      stall = ($urandom_range(99) < stall_pct);
      m = 3'($urandom_range(7, 1));
      jr_pc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      if ((instr_valid_id && !in_delay && $urandom_range(99) < jump_pct) ||
          (!instr_valid_id && $urandom_range(9) == 0)) begin
        jump_reg    = m[2];
        jump_target = m[1];
        jump_branch = m[0];
      end
    end

    // model: an instruction leaves ID at the coming edge
    if (instr_valid_id && !stall) begin
      check_eq("pc_id", pc_id, exp_pc);
      check_eq("instr_id", instr_id, mem_word(exp_pc));
      if (gap_expect > 0) begin
        if (gap_skip > 0) gap_skip--;
        else check_eq("issue_gap", 32'(cyc - last_cons), 32'(gap_expect));
      end
      last_cons = cyc;
      if (in_delay) begin
        exp_pc   = saved_target;
        in_delay = 1'b0;
      end else if (jump_reg || jump_target || jump_branch) begin
        saved_target = model_target(exp_pc, mem_word(exp_pc), jump_reg, jump_target,
                                    jump_branch, jr_pc);
        in_delay = 1'b1;
        exp_pc   = exp_pc + 32'd4;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
      consumed++;
    end

    hold_prev  = instr_valid_id && stall;
    held_pc    = pc_id;
    held_instr = instr_id;
    prev_req   = imem_req;
    prev_ready = imem_ready;
    prev_addr  = imem_addr;
  endtask

  // Asynchronous reset pulse in the middle of a cycle, with a stray response
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid_id), 32'd0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_pc_id", pc_id, 32'h0);
    check_eq("rst_instr", instr_id, NOP);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hold_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    clear_bench_state();
  endtask

  initial begin
    int n;
    cyc = 0; last_cons = 0; consumed = 0;
    directed = 1'b1; mem_ident = 1'b1;
    st_done = 1'b0; st_cnt = 0; jr_st = 0;
    set_phase(0, 0, 0, 0);
    clear_bench_state();
    ovr[32'h20]      = 32'h1000_0004;   // beq, imm 4
    ovr[32'h40]      = 32'h0800_0100;   // j, index 0x100
    lat_ovr[32'h44]  = 2;

    // power-on reset
    repeat (3) @(negedge clk);
    check_eq("por_req", 32'(imem_req), 32'd0);
    check_eq("por_addr", imem_addr, RESET_PC);
    check_eq("por_pc_id", pc_id, 32'h0);
    check_eq("por_instr", instr_id, NOP);
    check_eq("por_valid", 32'(instr_valid_id), 32'd0);
    rst_n = 1'b1;

    // zero-wait back-to-back issue
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("seq_addr", imem_addr, 32'(4 * k));
      check_eq("seq_req", 32'(imem_req), 32'd1);
      if (k > 0) begin
        check_eq("seq_pc_id", pc_id, 32'(4 * (k - 1)));
        check_eq("seq_valid", 32'(instr_valid_id), 32'd1);
      end
    end

    // skid stall at 0x10, beq at 0x20, j at 0x40 with slow delay slot, jr under stall
    n = 0;
    while (exp_pc != 32'h0000_1010 && n < 300) begin
      tick();
      n++;
    end
    check_eq("directed_reach", exp_pc, 32'h0000_1010);

    // reset in the middle of a slow request
    lat_fixed = 3;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(imem_req && !imem_ready) && n < 20);
    check_eq("mid_req_seen", 32'(imem_req && !imem_ready), 32'd1);
    ovr.delete();
    lat_ovr.delete();
    mem_ident = 1'b0;
    directed  = 1'b0;
    async_reset();
    tick();
    check_eq("first_fetch_req", 32'(imem_req), 32'd1);
    check_eq("first_fetch_addr", imem_addr, RESET_PC);

    set_phase(0, 0, 0, 1);
    repeat (30) tick();
    set_phase(3, 0, 0, 4);
    repeat (40) tick();
    set_phase(-1, 30, 25, 0);
    repeat (2500) tick();
    async_reset();
    repeat (800) tick();

    check_eq("progress", 32'(consumed >= 300), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
